imem_fetch: RTL and testbench
=============================

# imem_fetch

Instruction fetch front-end between the single-cycle CPU's PC output and a variable-latency instruction memory. A small direct-mapped instruction buffer holds recently fetched words. On a miss it runs a req/ack refill and asserts `stall` to freeze the PC, and it drives a NOP onto `instr` so the CPU commits nothing while waiting. Hit and miss counters are provided for debug and performance readout.

## Interface
Parameters:
- `ENTRIES`, 4: buffer entries; power of two, at least 2. `IW = log2(ENTRIES)`.
- `CNT_W`, 16: width of the hit and miss counters.

Ports:
- `clk`  in  1: clock. The block uses this single clock only.
- `rst`  in  1: reset, synchronous and active-high.
- `pc`  in  32: fetch address from the PC register. Bits [1:0] are ignored.
- `flush`  in  1: invalidate all entries.
- `instr`  out  32: instruction to the CPU decoder.
- `stall`  out  1: freezes the PC register when high.
- `mem_req`  out  1: refill request to instruction memory.
- `mem_addr`  out  32: word-aligned refill address.
- `mem_ack`  in  1: memory has returned data this cycle.
- `mem_rdata`  in  32: refill data, valid only while `mem_ack`=1.
- `hit_cnt`  out  CNT_W: count of hit cycles, saturating.
- `miss_cnt`  out  CNT_W: count of refills started, saturating.

## Operation
Address split:
- index = `pc[IW+1:2]`
- tag = `pc[31:IW+2]`

Per-entry storage: `valid`, tag, 32-bit data.

`hit` = `valid[index]` && tag match && state==IDLE && !`flush`.

Outputs by condition:
- `hit`=1: `instr` = entry data (combinational), `stall`=0.
- `hit`=0: `instr` = 32'h0000_0000 (sll $0,$0,0), `stall`=1.

FSM, two states:
- IDLE: on a miss with `flush`=0, latch `mem_addr` <= {`pc[31:2]`,2'b00}, set `mem_req` <= 1, go to REQ. A hit stays in IDLE.
- REQ: `mem_req`=1 and `mem_addr` held stable. On `mem_ack`=1:
  - write `mem_rdata` and the tag into the entry selected by the latched address, set its `valid`;
  - set `mem_req` <= 0 and return to IDLE.
- REQ without `mem_ack`: wait indefinitely. There is no timeout.

Flush:
- `flush` clears every `valid` bit at the clock edge.
- `flush` during REQ: the transaction still completes on `mem_ack`, but the fill is discarded (`valid` stays 0). A sticky `drop` flag records this and clears on return to IDLE.
- `flush` and `mem_ack` in the same cycle: the flush wins and nothing is filled.

Counters:
- `hit_cnt` increments on every cycle with `hit`=1.
- `miss_cnt` increments on every IDLE->REQ transition.
- Both saturate at all-ones and never wrap.

`mem_ack` received in IDLE is ignored.

## Timing
- Reset, after the first rising edge with `rst`=1:
  - state IDLE; all `valid`=0; `drop`=0;
  - `mem_req`=0, `mem_addr`=0, `hit_cnt`=0, `miss_cnt`=0;
  - `stall`=1 and `instr`=0 whenever the current `pc` misses.
- `rst` in REQ aborts the refill: `mem_req` drops next cycle and nothing is filled.
- Hit latency: 0 cycles; `instr` is combinational from `pc`.
- Miss timeline:
  - cycle 0: miss detected, `stall`=1.
  - cycle 1: `mem_req`=1.
  - cycle k≥1: `mem_ack`=1; fill happens at the end of cycle k.
  - cycle k+1: hit, `stall`=0.
  - Minimum penalty is 2 stall cycles, when `mem_ack` arrives in cycle 1.
- `stall` is combinational. The PC is frozen while `stall`=1, so `pc` is stable for the whole miss.
- Aliasing: two addresses with the same index and different tags evict each other. Each access pays a full miss.

## Test plan
1. Reset, then `pc`=0x0000_3000, memory acks 1 cycle after `mem_req`:
   - cycle 0: `stall`=1, `instr`=0.
   - cycle 1: `mem_req`=1, `mem_addr`=0x3000.
   - cycle 2: `instr`=`mem_rdata`, `stall`=0.
   - `miss_cnt`=1.
2. Re-present 0x3000 for 5 cycles after the fill -> `stall`=0 every cycle, `hit_cnt`=5, no `mem_req`.
3. With ENTRIES=4, fetch 0x3000 then 0x3010 (same index 0, different tag), then 0x3000 again -> three refills, `miss_cnt`=3.
4. Assert `flush` in cycle 2 of a 4-cycle-latency refill -> `mem_ack` is accepted, `valid` stays 0, and the next cycle misses again with `miss_cnt`+1.
5. Assert `rst` mid-REQ -> `mem_req`=0, all `valid`=0 and counters 0 next cycle. A late `mem_ack` is ignored.
6. Preload `hit_cnt` near saturation with CNT_W=4: 20 hit cycles -> `hit_cnt` holds at 4'hF.

Source files
------------

// File: rtl/imem_fetch.sv
// Instruction fetch front-end: direct-mapped instruction buffer with a req/ack refill
// from variable-latency memory, stalling the CPU and driving NOPs while a miss is pending.
module imem_fetch #(
    parameter int ENTRIES = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc,
    input  logic             flush,
    output logic [31:0]      instr,
    output logic             stall,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int IW    = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IW;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t             state_reg, state_next;
    logic               mem_req_reg, mem_req_next;
    logic [31:0]        mem_addr_reg, mem_addr_next;
    logic               drop_reg, drop_next;
    logic [CNT_W-1:0]   hit_cnt_reg, hit_cnt_next;
    logic [CNT_W-1:0]   miss_cnt_reg, miss_cnt_next;

    logic               valid_reg [ENTRIES];
    logic [TAG_W-1:0]   tag_reg   [ENTRIES];
    logic [31:0]        data_reg  [ENTRIES];

    logic [IW-1:0]      pc_idx;
    logic [TAG_W-1:0]   pc_tag;
    logic [IW-1:0]      fill_idx;
    logic               hit;
    logic               fill_en;
    logic               refill_start;

    assign pc_idx   = pc[IW+1:2];
    assign pc_tag   = pc[31:IW+2];
    assign fill_idx = mem_addr_reg[IW+1:2];

    assign hit = valid_reg[pc_idx] && (tag_reg[pc_idx] == pc_tag)
                 && (state_reg == IDLE) && !flush;

    // A flush seen at any point of the refill (tracked by drop_reg, or in the ack
    // cycle itself) discards the returning word.
    assign fill_en = (state_reg == REQ) && mem_ack && !drop_reg && !flush;

    assign instr    = hit ? data_reg[pc_idx] : 32'h0000_0000;
    assign stall    = !hit;
    assign mem_req  = mem_req_reg;
    assign mem_addr = mem_addr_reg;
    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    valid_reg[gi] <= 1'b0;
                end else if (fill_en && (fill_idx == IW'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (fill_en && (fill_idx == IW'(gi))) begin
                    tag_reg[gi]  <= mem_addr_reg[31:IW+2];
                    data_reg[gi] <= mem_rdata;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        mem_req_next  = mem_req_reg;
        mem_addr_next = mem_addr_reg;
        drop_next     = drop_reg;
        refill_start  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!hit && !flush) begin
                    state_next    = REQ;
                    mem_req_next  = 1'b1;
                    mem_addr_next = {pc[31:2], 2'b00};
                    drop_next     = 1'b0;
                    refill_start  = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                    drop_next    = 1'b0;
                end else if (flush) begin
                    drop_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        hit_cnt_next  = hit_cnt_reg;
        miss_cnt_next = miss_cnt_reg;
        if (hit && (hit_cnt_reg != {CNT_W{1'b1}})) begin
            hit_cnt_next = hit_cnt_reg + 1'b1;
        end
        if (refill_start && (miss_cnt_reg != {CNT_W{1'b1}})) begin
            miss_cnt_next = miss_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= 32'h0000_0000;
            drop_reg     <= 1'b0;
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            mem_req_reg  <= mem_req_next;
            mem_addr_reg <= mem_addr_next;
            drop_reg     <= drop_next;
            hit_cnt_reg  <= hit_cnt_next;
            miss_cnt_reg <= miss_cnt_next;
        end
    end
endmodule

// File: tb/tb_imem_fetch.sv
// Self-checking bench for imem_fetch: table of fetch vectors with a memory responder,
// an expected-instruction scoreboard, and hand sequences for reset and saturation.
module tb_imem_fetch;
    localparam int ENTRIES = 4;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      pc;
    logic             flush;
    logic [31:0]      instr;
    logic             stall;
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic             mem_ack;
    logic [31:0]      mem_rdata;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    imem_fetch #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .flush    (flush),
        .instr    (instr),
        .stall    (stall),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          lat;
        int          fl_cyc;
        int          reps;
        int          exp_stalls;
        int          exp_miss;
        int          exp_hit;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_0001;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Presents one address until it hits, acting as memory that acks lat cycles after
    // mem_req rises. Caller is positioned 1 time unit after a rising edge.
    task automatic do_fetch(input logic [31:0] a, input int lat, input int fl_cyc,
                            output int stalls);
        int          req_n;
        bit          done;
        logic [31:0] exp;
        req_n  = 0;
        done   = 0;
        stalls = 0;
        exp_q.push_back(mem_word({a[31:2], 2'b00}));
        for (int c = 0; c < 200 && !done; c++) begin
            pc    = a;
            flush = (c == fl_cyc);
            if (mem_req) req_n++;
            mem_ack   = mem_req && (req_n == lat);
            mem_rdata = mem_ack ? mem_word({a[31:2], 2'b00}) : $urandom;
            if (mem_ack) req_n = 0;
            #1;
            if (stall) begin
                stalls++;
                check("nop_while_stalled", instr, 32'h0);
                if (c == 1) begin
                    check("req_in_cycle1", {31'h0, mem_req}, 32'h1);
                    check("req_addr", mem_addr, {a[31:2], 2'b00});
                end
            end else begin
                done = 1;
                exp  = exp_q.pop_front();
                check("hit_instr", instr, exp);
                check("no_req_on_hit", {31'h0, mem_req}, 32'h0);
            end
            @(posedge clk);
            #1;
        end
        flush   = 1'b0;
        mem_ack = 1'b0;
        if (!done) begin
            check("fetch_timeout", 32'h0, 32'h1);
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        int stalls;
        int exp_h;

        vecs[0]  = '{32'h0000_3000, 1, -1, 1, 2,  1, 1};
        vecs[1]  = '{32'h0000_3000, 1, -1, 5, 0,  1, 6};
        vecs[2]  = '{32'h0000_3010, 2, -1, 1, 3,  2, 7};
        vecs[3]  = '{32'h0000_3000, 3, -1, 1, 4,  3, 8};
        vecs[4]  = '{32'h0000_3004, 1, -1, 1, 2,  4, 9};
        vecs[5]  = '{32'h0000_3004, 1, -1, 2, 0,  4, 11};
        vecs[6]  = '{32'h0000_3000, 1, -1, 1, 0,  4, 12};
        vecs[7]  = '{32'h0000_4008, 4,  2, 1, 10, 6, 13};
        vecs[8]  = '{32'h0000_3000, 1, -1, 1, 2,  7, 14};
        vecs[9]  = '{32'h0000_4008, 1, -1, 1, 0,  7, 15};
        vecs[10] = '{32'h0000_4008, 1, -1, 2, 0,  7, 15};

        rst       = 1'b1;
        pc        = 32'h0000_3000;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        @(posedge clk);
        #1;
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_hit_cnt", 32'(hit_cnt), 32'h0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h1);
        check("rst_instr", instr, 32'h0);
        rst = 1'b0;

        for (int v = 0; v < 11; v++) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                do_fetch(vecs[v].pc, vecs[v].lat, vecs[v].fl_cyc, stalls);
                check("stall_cycles", 32'(stalls), 32'(vecs[v].exp_stalls));
            end
            check("miss_cnt", 32'(miss_cnt), 32'(vecs[v].exp_miss));
            check("hit_cnt", 32'(hit_cnt), 32'(vecs[v].exp_hit));
            $display("vec %0d: pc=%h x%0d stalls=%0d miss_cnt=%0d hit_cnt=%0d",
                     v, vecs[v].pc, vecs[v].reps, stalls, miss_cnt, hit_cnt);
        end

        // Reset in the middle of a refill, then a stray ack while idle.
        pc = 32'h0000_5000;
        #1;
        check("mid_rst_miss", {31'h0, stall}, 32'h1);
        @(posedge clk);
        #1;
        check("mid_rst_req", {31'h0, mem_req}, 32'h1);
        check("mid_rst_addr", mem_addr, 32'h0000_5000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_req", {31'h0, mem_req}, 32'h0);
        check("abort_addr", mem_addr, 32'h0);
        check("abort_hit_cnt", 32'(hit_cnt), 32'h0);
        check("abort_miss_cnt", 32'(miss_cnt), 32'h0);
        pc        = 32'h0000_3000;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        #1;
        check("valid_cleared", {31'h0, stall}, 32'h1);
        check("valid_cleared_instr", instr, 32'h0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        #1;
        check("idle_ack_ignored", {31'h0, stall}, 32'h1);
        check("refill_started", {31'h0, mem_req}, 32'h1);
        check("refill_miss_cnt", 32'(miss_cnt), 32'h1);
        do_fetch(32'h0000_3000, 1, -1, stalls);
        check("post_rst_stalls", 32'(stalls), 32'h1);
        $display("reset-abort: miss_cnt=%0d hit_cnt=%0d", miss_cnt, hit_cnt);

        // Hit counter saturation.
        exp_h = 1;
        for (int r = 0; r < 20; r++) begin
            do_fetch(32'h0000_3000, 1, -1, stalls);
            exp_h = (exp_h < 15) ? exp_h + 1 : 15;
            check("sat_hit_cnt", 32'(hit_cnt), 32'(exp_h));
        end
        check("sat_miss_cnt", 32'(miss_cnt), 32'h1);
        $display("saturation: hit_cnt=%0d after 20 hits", hit_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
